// File: rtl/program_counter_ras.sv
// program_counter_ras
//   MIPS program counter with next-PC selection (sequential, branch, jump,
//   jump-register, return prediction), pipeline stall hold, configurable reset
//   vector, program-space bounds/alignment fault detection and a small
//   circular return-address stack (RAS) serving jal/jr $ra.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous reset, active low
//   stall          hold PC and RAS this cycle
//   pc_src         conditional branch taken
//   Jump           j/jal
//   JumpReg        jr/jalr
//   Link           jal/jalr: push return address
//   ret            JumpReg is a return (jr $ra): use RAS prediction
//   Instr          current instruction, [25:0] is the jump index
//   sign_imm       sign-extended branch offset in words
//   reg_target     rs value for jr/jalr
//   PC             current program counter (instruction memory address)
//   pc_plus4       PC + 4 for link writeback
//   ras_empty      RAS holds no valid entries
//   ras_full       RAS holds RAS_DEPTH valid entries
//   addr_fault     one-cycle pulse: redirect out of range or misaligned
//   ras_underflow  one-cycle pulse: return with RAS empty
module program_counter_ras #(
  parameter int NUM_BITS_ADDR_BARRAMENTO = 32,
  parameter int NUM_BITS_ADDR_PROG       = 8,
  parameter logic [NUM_BITS_ADDR_BARRAMENTO-1:0] RESET_VECTOR = 32'h0,
  parameter int RAS_DEPTH                = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       stall,
  input  logic                                       pc_src,
  input  logic                                       Jump,
  input  logic                                       JumpReg,
  input  logic                                       Link,
  input  logic                                       ret,
  input  logic [31:0]                                Instr,
  input  logic signed [NUM_BITS_ADDR_BARRAMENTO-1:0] sign_imm,
  input  logic [NUM_BITS_ADDR_BARRAMENTO-1:0]        reg_target,
  output logic [NUM_BITS_ADDR_BARRAMENTO-1:0]        PC,
  output logic [NUM_BITS_ADDR_BARRAMENTO-1:0]        pc_plus4,
  output logic                                       ras_empty,
  output logic                                       ras_full,
  output logic                                       addr_fault,
  output logic                                       ras_underflow
);

  localparam int W     = NUM_BITS_ADDR_BARRAMENTO;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  // Address must be word aligned and inside the program space.
  function automatic logic out_of_bounds(input logic [W-1:0] a);
    out_of_bounds = (a[1:0] != 2'b00) || ((a >> NUM_BITS_ADDR_PROG) != '0);
  endfunction

  // Count saturates at the stack depth; a push when full overwrites the oldest.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == FULL_CNT) ? c : c + CNT_W'(1);
  endfunction

  logic [W-1:0]     pc_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [PTR_W-1:0] top_p0;   // next free slot; top entry sits one below
  logic [W-1:0]     ras_p0 [RAS_DEPTH];
  logic             fault_p0;
  logic             uflow_p0;

  logic [W-1:0] branch_target;
  logic [W-1:0] jump_target;
  logic [W-1:0] ras_top;
  logic [W-1:0] next_pc;
  logic         do_pop;
  logic         do_push;
  logic         uflow;
  logic         seq_path;
  logic         bad_addr;
  logic         unused_instr_bits;

  assign unused_instr_bits = ^Instr[31:26];

  assign pc_plus4      = pc_p0 + W'(4);
  assign branch_target = pc_plus4 + W'(sign_imm <<< 2);
  assign jump_target   = {pc_plus4[W-1:W-4], Instr[25:0], 2'b00};
  assign ras_top       = ras_p0[top_p0 - PTR_W'(1)];
  assign ras_empty     = (cnt_p0 == '0);
  assign ras_full      = (cnt_p0 == FULL_CNT);
  assign do_push       = Link && (Jump || JumpReg);
  assign bad_addr      = out_of_bounds(next_pc);

  always_comb begin
    next_pc  = pc_plus4;
    do_pop   = 1'b0;
    uflow    = 1'b0;
    seq_path = 1'b0;
    if (Jump) begin
      next_pc = jump_target;
    end else if (JumpReg && ret && !Link && !ras_empty) begin
      next_pc = ras_top;
      do_pop  = 1'b1;
    end else if (JumpReg) begin
      next_pc = reg_target;
      uflow   = ret && !Link;
    end else if (pc_src) begin
      next_pc = branch_target;
    end else begin
      seq_path = 1'b1;
    end
  end

  // ---- PC / RAS control register stage ----
  // A sequential step past the end of program space wraps to the reset
  // vector silently; any redirect landing outside it is a fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0    <= RESET_VECTOR;
      cnt_p0   <= '0;
      top_p0   <= '0;
      fault_p0 <= 1'b0;
      uflow_p0 <= 1'b0;
    end else if (stall) begin
      fault_p0 <= 1'b0;
      uflow_p0 <= 1'b0;
    end else begin
      pc_p0    <= bad_addr ? RESET_VECTOR : next_pc;
      fault_p0 <= bad_addr && !seq_path;
      uflow_p0 <= uflow;
      if (do_push) begin
        top_p0 <= top_p0 + PTR_W'(1);
        cnt_p0 <= sat_inc(cnt_p0);
      end else if (do_pop) begin
        top_p0 <= top_p0 - PTR_W'(1);
        cnt_p0 <= cnt_p0 - CNT_W'(1);
      end
    end
  end

  // ---- RAS entry storage (data, not reset) ----
  always_ff @(posedge clk) begin
    if (!stall && do_push) begin
      ras_p0[top_p0] <= pc_plus4;
    end
  end

  assign PC            = pc_p0;
  assign addr_fault    = fault_p0;
  assign ras_underflow = uflow_p0;

endmodule

// File: tb/tb_program_counter_ras.sv
// tb_program_counter_ras
//   Directed, table-driven bench for program_counter_ras with default
//   parameters (32-bit bus, 256-byte program space, reset vector 0, RAS depth 4).
module tb_program_counter_ras;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        pc_src;
  logic        Jump;
  logic        JumpReg;
  logic        Link;
  logic        ret;
  logic [31:0] Instr;
  logic signed [31:0] sign_imm;
  logic [31:0] reg_target;
  logic [31:0] PC;
  logic [31:0] pc_plus4;
  logic        ras_empty;
  logic        ras_full;
  logic        addr_fault;
  logic        ras_underflow;

  int n_checks;
  int n_fail;

  program_counter_ras dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .pc_src        (pc_src),
    .Jump          (Jump),
    .JumpReg       (JumpReg),
    .Link          (Link),
    .ret           (ret),
    .Instr         (Instr),
    .sign_imm      (sign_imm),
    .reg_target    (reg_target),
    .PC            (PC),
    .pc_plus4      (pc_plus4),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .addr_fault    (addr_fault),
    .ras_underflow (ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {stall, pc_src, Jump, JumpReg, Link, ret}
  // flg = {ras_empty, ras_full, addr_fault, ras_underflow} expected after the edge
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] rt;
    logic [31:0] e_pc;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [5:0] ctl, input logic [31:0] instr,
                              input logic [31:0] imm, input logic [31:0] rt,
                              input logic [31:0] e_pc, input logic [3:0] flg);
    vec_t v;
    v.ctl = ctl; v.instr = instr; v.imm = imm; v.rt = rt;
    v.e_pc = e_pc; v.flg = flg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    stall = 0; pc_src = 0; Jump = 0; JumpReg = 0; Link = 0; ret = 0;
    Instr = 0; sign_imm = 0; reg_target = 0;
  endtask

  task automatic apply(input vec_t v);
    {stall, pc_src, Jump, JumpReg, Link, ret} = v.ctl;
    Instr = v.instr; sign_imm = v.imm; reg_target = v.rt;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [3:0] flg);
    chk({tag, " pc"},       PC, e_pc);
    chk({tag, " pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, " empty"},    {31'd0, ras_empty},     {31'd0, flg[3]});
    chk({tag, " full"},     {31'd0, ras_full},      {31'd0, flg[2]});
    chk({tag, " fault"},    {31'd0, addr_fault},    {31'd0, flg[1]});
    chk({tag, " uflow"},    {31'd0, ras_underflow}, {31'd0, flg[0]});
  endtask

  initial begin
    logic [31:0] exp_pc;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = mk(6'b000000, 32'h0,  32'h0,        32'h0,   32'h04, 4'b1000);
    vecs[1]  = mk(6'b001000, 32'h4,  32'h0,        32'h0,   32'h10, 4'b1000);
    vecs[2]  = mk(6'b010000, 32'h0,  32'hFFFFFFFE, 32'h0,   32'h0C, 4'b1000);
    vecs[3]  = mk(6'b001000, 32'h4,  32'h0,        32'h0,   32'h10, 4'b1000);
    vecs[4]  = mk(6'b011000, 32'h20, 32'h0,        32'h0,   32'h80, 4'b1000);
    vecs[5]  = mk(6'b001000, 32'h8,  32'h0,        32'h0,   32'h20, 4'b1000);
    vecs[6]  = mk(6'b001010, 32'h10, 32'h0,        32'h0,   32'h40, 4'b0000);
    vecs[7]  = mk(6'b000000, 32'h0,  32'h0,        32'h0,   32'h44, 4'b0000);
    vecs[8]  = mk(6'b000101, 32'h0,  32'h0,        32'h99,  32'h24, 4'b1000);
    vecs[9]  = mk(6'b001000, 32'h0,  32'h0,        32'h0,   32'h00, 4'b1000);
    vecs[10] = mk(6'b001010, 32'h4,  32'h0,        32'h0,   32'h10, 4'b0000);
    vecs[11] = mk(6'b001010, 32'h8,  32'h0,        32'h0,   32'h20, 4'b0000);
    vecs[12] = mk(6'b001010, 32'hC,  32'h0,        32'h0,   32'h30, 4'b0000);
    vecs[13] = mk(6'b001010, 32'h10, 32'h0,        32'h0,   32'h40, 4'b0100);
    vecs[14] = mk(6'b001010, 32'h20, 32'h0,        32'h0,   32'h80, 4'b0100);
    vecs[15] = mk(6'b000101, 32'h0,  32'h0,        32'h08,  32'h44, 4'b0000);
    vecs[16] = mk(6'b000101, 32'h0,  32'h0,        32'h08,  32'h34, 4'b0000);
    vecs[17] = mk(6'b000101, 32'h0,  32'h0,        32'h08,  32'h24, 4'b0000);
    vecs[18] = mk(6'b000101, 32'h0,  32'h0,        32'h08,  32'h14, 4'b1000);
    vecs[19] = mk(6'b000101, 32'h0,  32'h0,        32'h08,  32'h08, 4'b1001);
    vecs[20] = mk(6'b000000, 32'h0,  32'h0,        32'h0,   32'h0C, 4'b1000);
    vecs[21] = mk(6'b000100, 32'h0,  32'h0,        32'h102, 32'h00, 4'b1010);
    vecs[22] = mk(6'b000000, 32'h0,  32'h0,        32'h0,   32'h04, 4'b1000);
    vecs[23] = mk(6'b000100, 32'h0,  32'h0,        32'h06,  32'h00, 4'b1010);
    vecs[24] = mk(6'b000110, 32'h0,  32'h0,        32'h100, 32'h00, 4'b0010);
    vecs[25] = mk(6'b000101, 32'h0,  32'h0,        32'h0,   32'h04, 4'b1000);
    vecs[26] = mk(6'b010000, 32'h0,  32'h40,       32'h0,   32'h00, 4'b1010);
    vecs[27] = mk(6'b000010, 32'h0,  32'h0,        32'h0,   32'h04, 4'b1000);
    vecs[28] = mk(6'b000111, 32'h0,  32'h0,        32'h20,  32'h20, 4'b0000);
    vecs[29] = mk(6'b000101, 32'h0,  32'h0,        32'h0,   32'h08, 4'b1000);
    vecs[30] = mk(6'b101000, 32'h20, 32'h0,        32'h0,   32'h08, 4'b1000);
    vecs[31] = mk(6'b101000, 32'h20, 32'h0,        32'h0,   32'h08, 4'b1000);
    vecs[32] = mk(6'b101101, 32'h0,  32'h0,        32'h06,  32'h08, 4'b1000);
    vecs[33] = mk(6'b000000, 32'h0,  32'h0,        32'h0,   32'h0C, 4'b1000);

    // Reset state
    idle();
    reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_state("reset", 32'h0, 4'b1000);
    reset = 1'b1;

    // Sequential stepping through the whole program space and wrap to 0
    exp_pc = 32'h0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      exp_pc = (exp_pc + 32'd4) & 32'hFF;
      chk_state($sformatf("seq%0d", i), exp_pc, 4'b1000);
    end

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      @(posedge clk); #1;
      chk_state($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].flg);
    end

    // jal to 0x40, then stall with a jump pending, then async reset mid-stall
    idle();
    Jump = 1; Link = 1; Instr = 32'h10;
    @(posedge clk); #1;
    chk_state("jal_pre_stall", 32'h40, 4'b0000);
    idle();
    stall = 1; Jump = 1; Instr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_state($sformatf("stall%0d", i), 32'h40, 4'b0000);
    end
    #3;
    reset = 1'b0;
    #1;
    chk_state("async_reset", 32'h0, 4'b1000);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    chk_state("post_reset", 32'h4, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter_ras.md
Name: program_counter_ras

Overview:
- Parametrised next-generation MIPS program counter.
- Selects the next PC from sequential, branch, jump, jump-register and return-prediction sources.
- Adds a pipeline stall hold, a configurable reset vector, fault-checked program-space bounds and a small circular return-address stack (RAS) for jal/jr $ra.
- Sits between the control unit and instruction_memory; the PC output drives the instruction memory address.

Parameters:
- NUM_BITS_ADDR_BARRAMENTO, 32: bus/PC width. Kept at 32 for the MIPS architecture.
- NUM_BITS_ADDR_PROG, 8: log2 of program memory size in bytes. Must match instruction_memory.
- RESET_VECTOR, 32'h0: PC value after reset and after a fault. Word aligned, below 2**NUM_BITS_ADDR_PROG.
- RAS_DEPTH, 4: number of return-stack entries. Power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- stall  in  1  hold PC and RAS this cycle.
- pc_src  in  1  conditional branch taken.
- Jump  in  1  j/jal.
- JumpReg  in  1  jr/jalr.
- Link  in  1  jal/jalr; push return address.
- ret  in  1  JumpReg is a return (jr $ra); use the RAS prediction.
- Instr  in  32  current instruction; [25:0] is the jump index.
- sign_imm  in  32 (signed)  sign-extended branch offset, in words.
- reg_target  in  32  rs register value for jr/jalr.
- PC  out  32  current program counter.
- pc_plus4  out  32  PC+4, for link writeback.
- ras_empty  out  1  RAS holds 0 valid entries.
- ras_full  out  1  RAS holds RAS_DEPTH valid entries.
- addr_fault  out  1  one-cycle pulse: redirect was out of range or misaligned.
- ras_underflow  out  1  one-cycle pulse: return with RAS empty.

Behaviour:
- Reset (reset==0, async, any time including mid-stall): PC=RESET_VECTOR, RAS count=0, top pointer=0, addr_fault=0, ras_underflow=0. Entry contents are don't-care.
- Combinational outputs: pc_plus4=PC+4, with 32-bit wrap.
- Target computations:
  - branch target = pc_plus4 + (sign_imm<<2), 32-bit wrap.
  - jump target = {pc_plus4[31:28], Instr[25:0], 2'b00}.
  - register target = reg_target.
- next PC priority, evaluated each unstalled edge:
  1. Jump: jump target.
  2. JumpReg with ret=1, Link=0 and RAS non-empty: RAS top entry, then pop.
  3. JumpReg otherwise: reg_target. If ret=1, Link=0 and RAS empty, pulse ras_underflow.
  4. pc_src: branch target.
  5. Otherwise: pc_plus4.
- Link with Jump or JumpReg: push pc_plus4. ret is ignored when Link=1. Link alone, with no jump, has no effect.
- Push when full: overwrite the oldest entry (circular). Count saturates at RAS_DEPTH; ras_full stays 1.
- Pop: count decrements and the top pointer moves back. Push and pop never occur in the same cycle.
- Bounds: if next PC >= 2**NUM_BITS_ADDR_PROG, or next PC[1:0]!=0:
  - PC <= RESET_VECTOR and addr_fault=1 for exactly that cycle.
  - A push requested in that cycle still occurs; a pop still occurs.
- Sequential wrap: pc_plus4 == 2**NUM_BITS_ADDR_PROG is a legal wrap, not a fault. PC <= RESET_VECTOR with addr_fault=0.
- stall=1: PC, RAS and count hold. addr_fault=0 and ras_underflow=0. All control inputs ignored.
- addr_fault and ras_underflow are registered pulses, cleared on the next edge.
- Latency: a redirect is visible on PC one cycle after the edge that samples it. No bubbles are inserted.

Test Plan:
- Reset and sequential: reset=0 then 1, RESET_VECTOR=0. PC steps 0,4,8,… up to 252, then 0 with no addr_fault; pc_plus4 is always PC+4.
- Branch/jump priority: PC=0x10, sign_imm=-2, pc_src=1 → PC=0x0C. At PC=0x10 with Jump=1, pc_src=1 and Instr[25:0]=0x20 → PC=0x80.
- Call/return: jal at PC=0x20 to 0x40 (Link=1) pushes 0x24. Later jr with ret=1 and reg_target=0x99 → PC=0x24 and ras_empty=1 afterward.
- RAS overflow and underflow: 5 jal pushes of 0x04,0x14,0x24,0x34,0x44 with depth 4 → ras_full=1. Four returns yield 0x44,0x34,0x24,0x14. A fifth return takes reg_target=0x08 with a ras_underflow pulse.
- Faults: jr to 0x102 (out of range) or 0x06 (misaligned) → PC=RESET_VECTOR with a one-cycle addr_fault.
- Stall and async reset: stall=1 with Jump=1 holds PC and RAS for 3 cycles. Asserting reset=0 between clock edges while stalled drives PC=RESET_VECTOR and ras_empty=1 immediately, with no clock edge needed.
